translit_word_sequencer: RTL and testbench

Word-level sequencer in front of the registered Hindi→English character mapper (`C2_mapping`, 7-bit `hindi` in, 7-bit `r5` out, one clock). It accepts a stream of 7-bit Hindi character codes over a valid/ready handshake and buffers one word, terminated by the space code. It then issues the buffered characters to the mapper back-to-back and collects the mapped codes. Finally it streams the English word, followed by a space delimiter, over a second valid/ready handshake.

---
 rtl/translit_word_sequencer.sv | 166 ++++++++++++++++
 tb/tb_translit_word_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/translit_word_sequencer.sv
// translit_word_sequencer
//   Buffers one SPACE-terminated word of 7-bit Hindi codes, pushes it
//   back-to-back through an external registered character mapper, collects the
//   mapped codes, then streams the English word plus a closing SPACE.
//
// Ports
//   clock, reset_n            single clock, async active-low reset
//   in_valid/in_ready/in_char Hindi character stream (in_ready registered)
//   map_hindi -> mapper input, map_r5 <- mapper output (MAP_LAT cycles later)
//   out_valid/out_ready/out_char/out_last  English stream, out_last on delimiter
//   overflow                  one-cycle pulse when a word is cut at MAX_WORD
module translit_word_sequencer #(
  parameter int         MAX_WORD = 16,
  parameter logic [6:0] SPACE    = 7'b0110000,
  parameter int         MAP_LAT  = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_char,
  output logic [6:0] map_hindi,
  input  logic [6:0] map_r5,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_char,
  output logic       out_last,
  output logic       overflow
);

  localparam int IW = $clog2(MAX_WORD + 1);  // cnt / ii / ei width
  localparam int AW = $clog2(MAX_WORD);      // buffer address width
  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [IW-1:0] FULL = IW'(MAX_WORD - 1);

  typedef enum logic [1:0] {S_COLLECT, S_MAP, S_DRAIN, S_EMIT} state_e;

  state_e                     state_q, state_d;
  logic [IW-1:0]              cnt_q, cnt_d;
  logic [IW-1:0]              ii_q, ii_d;
  logic [IW-1:0]              ei_q, ei_d;
  logic                       in_ready_q, in_ready_d;
  logic                       overflow_q, overflow_d;
  logic [MAX_WORD-1:0][6:0]   ibuf_q, ibuf_d;
  logic [MAX_WORD-1:0][6:0]   obuf_q, obuf_d;
  // Issue tags travelling alongside the mapper: stage 1 is loaded on issue,
  // stage MAP_LAT lines up with the matching map_r5.
  logic [MAP_LAT:1]           vld_pipe_q, vld_pipe_d;
  logic [MAP_LAT:1][IW-1:0]   idx_pipe_q, idx_pipe_d;

  logic in_acc;
  logic emit_end;

  assign in_acc   = in_ready_q & in_valid;
  assign emit_end = (ei_q == cnt_q);

  // Outputs are decoded straight from flops so an async reset clears them
  // in the same instant.
  assign in_ready  = in_ready_q;
  assign overflow  = overflow_q;
  assign out_valid = (state_q == S_EMIT);
  assign out_last  = (state_q == S_EMIT) & emit_end;
  assign map_hindi = (state_q == S_MAP) ? ibuf_q[ii_q[AW-1:0]] : 7'd0;

  always_comb begin
    out_char = 7'd0;
    if (state_q == S_EMIT) out_char = emit_end ? SPACE : obuf_q[ei_q[AW-1:0]];
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ii_d          = ii_q;
    ei_d          = ei_q;
    overflow_d    = 1'b0;
    ibuf_d        = ibuf_q;
    obuf_d        = obuf_q;
    vld_pipe_d    = '0;
    idx_pipe_d    = '0;

    for (int s = 2; s <= MAP_LAT; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      idx_pipe_d[s] = idx_pipe_q[s-1];
    end

    // Capture only when a tag emerges; map_r5 is don't-care otherwise.
    if (vld_pipe_q[MAP_LAT]) obuf_d[idx_pipe_q[MAP_LAT][AW-1:0]] = map_r5;

    unique case (state_q)
      S_COLLECT: begin
        if (in_acc) begin
          if (in_char == SPACE) begin
            // Leading / repeated spaces are swallowed.
            if (cnt_q != '0) state_d = S_MAP;
          end else begin
            ibuf_d[cnt_q[AW-1:0]] = in_char;
            cnt_d = cnt_q + ONE;
            // Full buffer closes the word without waiting for a SPACE.
            if (cnt_q == FULL) begin
              state_d    = S_MAP;
              overflow_d = 1'b1;
            end
          end
        end
      end
      S_MAP: begin
        vld_pipe_d[1] = 1'b1;
        idx_pipe_d[1] = ii_q;
        if (ii_q == cnt_q - ONE) begin
          ii_d    = '0;
          state_d = S_DRAIN;
        end else begin
          ii_d = ii_q + ONE;
        end
      end
      S_DRAIN: begin
        // Leave once the final issue's result is being captured this cycle.
        if (vld_pipe_q[MAP_LAT] && idx_pipe_q[MAP_LAT] == cnt_q - ONE) begin
          ei_d    = '0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (emit_end) begin
            ei_d    = '0;
            cnt_d   = '0;
            state_d = S_COLLECT;
          end else begin
            ei_d = ei_q + ONE;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase

    in_ready_d = (state_d == S_COLLECT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_COLLECT;
      cnt_q      <= '0;
      ii_q       <= '0;
      ei_q       <= '0;
      in_ready_q <= 1'b0;
      overflow_q <= 1'b0;
      ibuf_q     <= '0;
      obuf_q     <= '0;
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ii_q       <= ii_d;
      ei_q       <= ei_d;
      in_ready_q <= in_ready_d;
      overflow_q <= overflow_d;
      ibuf_q     <= ibuf_d;
      obuf_q     <= obuf_d;
      vld_pipe_q <= vld_pipe_d;
      idx_pipe_q <= idx_pipe_d;
    end
  end

endmodule

// File: tb/tb_translit_word_sequencer.sv
// Directed bench: dut_a uses a 1-stage mapper, dut_b a 3-stage mapper.
module tb_translit_word_sequencer;
  localparam logic [6:0] SP = 7'b0110000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, iv_a, iv_b, out_ready;
  logic [6:0] in_char;
  logic       rdy_a, rdy_b, ov_a, ov_b, ol_a, ol_b, of_a, of_b;
  logic [6:0] mh_a, mh_b, r5_a, r5_b, oc_a, oc_b, p1_b, p2_b;

  int cyc = 0;
  int checks = 0, errors = 0;
  int sp_edge = 0, ovf_seen = 0;
  logic [6:0] hin [6];
  logic [6:0] eng [6];
  logic [6:0] exp_w [$];

  function automatic logic [6:0] map_fn(input logic [6:0] h);
    case (h)
      7'b1010011: return 7'b1000010;
      7'b0000000: return 7'b0000000;
      7'b1011100: return 7'b1001101;
      7'b1011110: return 7'b1010000;
      7'b0000001: return 7'b0010101;
      7'b1000111: return 7'b1000110;
      default:    return ~h;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) r5_a <= map_fn(mh_a);
  always @(posedge clk) begin
    p1_b <= map_fn(mh_b);
    p2_b <= p1_b;
    r5_b <= p2_b;
  end

  translit_word_sequencer #(.MAX_WORD(16), .SPACE(SP), .MAP_LAT(1)) dut_a (
    .clock(clk), .reset_n(rst_n), .in_valid(iv_a), .in_ready(rdy_a),
    .in_char(in_char), .map_hindi(mh_a), .map_r5(r5_a), .out_valid(ov_a),
    .out_ready(out_ready), .out_char(oc_a), .out_last(ol_a), .overflow(of_a));

  translit_word_sequencer #(.MAX_WORD(16), .SPACE(SP), .MAP_LAT(3)) dut_b (
    .clock(clk), .reset_n(rst_n), .in_valid(iv_b), .in_ready(rdy_b),
    .in_char(in_char), .map_hindi(mh_b), .map_r5(r5_b), .out_valid(ov_b),
    .out_ready(out_ready), .out_char(oc_b), .out_last(ol_b), .overflow(of_b));

  function automatic int f_rdy(input bit b); return b ? int'(rdy_b) : int'(rdy_a); endfunction
  function automatic int f_ov (input bit b); return b ? int'(ov_b)  : int'(ov_a);  endfunction
  function automatic int f_ol (input bit b); return b ? int'(ol_b)  : int'(ol_a);  endfunction
  function automatic int f_of (input bit b); return b ? int'(of_b)  : int'(of_a);  endfunction
  function automatic int f_oc (input bit b); return b ? int'(oc_b)  : int'(oc_a);  endfunction
  function automatic int f_mh (input bit b); return b ? int'(mh_b)  : int'(mh_a);  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit b, input logic [6:0] c);
    int n = 0;
    in_char = c;
    if (b) iv_b = 1'b1; else iv_a = 1'b1;
    while (f_rdy(b) == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("in_rdy_timeout", f_rdy(b), 1);
    @(negedge clk);
    sp_edge = cyc;  // edges elapsed up to and including the accepting edge
    iv_a = 1'b0;
    iv_b = 1'b0;
  endtask

  // Collects one word against exp_w; exp_lat>0 checks edges from the last
  // accepted input to the edge completing the first output beat.
  task automatic get_word(input bit b, input bit toggle, input int exp_lat);
    int beats = 0, n = 0, exp_n;
    bit stalled = 0, first = 1;
    int held = 0;
    exp_n = exp_w.size();
    out_ready = 1'b1;
    while (beats <= exp_n && n < 300) begin
      @(negedge clk);
      n++;
      if (toggle) out_ready = ~out_ready;
      if (f_of(b) != 0) ovf_seen++;
      if (f_ov(b) != 0) begin
        if (first) begin
          first = 0;
          if (exp_lat > 0) chk("first_lat", cyc + 1 - sp_edge, exp_lat);
        end
        if (stalled) chk("hold", f_oc(b) * 2 + f_ol(b), held);
        if (out_ready) begin
          chk("char", f_oc(b), (beats < exp_n) ? int'(exp_w[beats]) : int'(SP));
          chk("last", f_ol(b), int'(beats == exp_n));
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = f_oc(b) * 2 + f_ol(b);
        end
      end
    end
    chk("beats", beats, exp_n + 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_vld", f_ov(b), 0);
    chk("rdy_back", f_rdy(b), 1);
  endtask

  task automatic run_davaat(input bit b, input int exp_lat);
    int seq [8];
    seq = '{0, 1, 2, 1, 3, 4, 5, 4};
    exp_w.delete();
    for (int i = 0; i < 8; i++) begin
      send(b, hin[seq[i]]);
      exp_w.push_back(eng[seq[i]]);
      repeat (4) @(negedge clk);
    end
    send(b, SP);
    chk("map_first", f_mh(b), int'(hin[0]));
    chk("busy", f_rdy(b), 0);
    get_word(b, 1'b0, exp_lat);
  endtask

  initial begin
    int bad_v, bad_r;
    hin = '{7'b1010011, 7'b0000000, 7'b1011100, 7'b1011110, 7'b0000001, 7'b1000111};
    eng = '{7'b1000010, 7'b0000000, 7'b1001101, 7'b1010000, 7'b0010101, 7'b1000110};
    rst_n = 1'b0; iv_a = 1'b0; iv_b = 1'b0; in_char = 7'd0; out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy", int'(rdy_a), 0);
    chk("rst_vld", int'(ov_a), 0);
    chk("rst_char", int'(oc_a), 0);
    chk("rst_last", int'(ol_a), 0);
    chk("rst_ovf", int'(of_a), 0);
    chk("rst_map", int'(mh_a), 0);
    chk("rst_rdy_b", int'(rdy_b), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", int'(rdy_a), 1);

    // davaat, 1-stage mapper
    run_davaat(1'b0, 10);

    // spaces only
    for (int i = 0; i < 3; i++) send(1'b0, SP);
    bad_v = 0; bad_r = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov_a) bad_v++;
      if (!rdy_a) bad_r++;
    end
    chk("sp_novalid", bad_v, 0);
    chk("sp_rdy", bad_r, 0);

    // output backpressure, 3-char word
    exp_w.delete();
    exp_w.push_back(eng[2]); exp_w.push_back(eng[3]); exp_w.push_back(eng[5]);
    send(1'b0, hin[2]); send(1'b0, hin[3]); send(1'b0, hin[5]); send(1'b0, SP);
    get_word(1'b0, 1'b1, 0);

    // overflow: 16 chars fill the word, 17th is held until the next word
    exp_w.delete();
    for (int i = 0; i < 16; i++) begin
      send(1'b0, hin[i % 6]);
      exp_w.push_back(eng[i % 6]);
    end
    chk("ovf_pulse", int'(of_a), 1);
    chk("ovf_busy", int'(rdy_a), 0);
    in_char = hin[4];
    iv_a = 1'b1;
    ovf_seen = 0;
    get_word(1'b0, 1'b0, 18);
    chk("ovf_once", ovf_seen, 0);
    @(negedge clk);  // 17th character accepted on the edge just passed
    iv_a = 1'b0;
    exp_w.delete();
    exp_w.push_back(eng[4]);
    send(1'b0, SP);
    get_word(1'b0, 1'b0, 3);

    // reset during the 3rd issue cycle
    send(1'b0, hin[0]); send(1'b0, hin[2]); send(1'b0, hin[3]);
    send(1'b0, hin[5]); send(1'b0, hin[1]); send(1'b0, SP);
    repeat (2) @(negedge clk);
    chk("map_3rd", int'(mh_a), int'(hin[3]));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rdy", int'(rdy_a), 0);
    chk("mid_vld", int'(ov_a), 0);
    chk("mid_char", int'(oc_a), 0);
    chk("mid_last", int'(ol_a), 0);
    chk("mid_ovf", int'(of_a), 0);
    chk("mid_map", int'(mh_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rdy_rel", int'(rdy_a), 1);
    bad_v = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov_a) bad_v++;
    end
    chk("mid_no_out", bad_v, 0);
    exp_w.delete();
    exp_w.push_back(eng[5]); exp_w.push_back(eng[0]);
    send(1'b0, hin[5]); send(1'b0, hin[0]); send(1'b0, SP);
    get_word(1'b0, 1'b0, 4);

    // davaat, 3-stage mapper
    run_davaat(1'b1, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
